// File: rtl/xtal_osc_32k_ctrl.sv
// Start-up controller and edge-rate clock monitor for the 32.768 kHz crystal oscillator.
// Sequences ena/boost, synchronizes dout and qualifies its edge rate over fixed windows.
module xtal_osc_32k_ctrl #(
    parameter int WIN_CYCLES      = 100000,
    parameter int MIN_EDGES       = 300,
    parameter int MAX_EDGES       = 356,
    parameter int BOOST_CYCLES    = 50000,
    parameter int STABLE_WINDOWS  = 4,
    parameter int TIMEOUT_WINDOWS = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        dout,
    output logic        osc_ena,
    output logic        osc_boost,
    output logic        ready,
    output logic        fail,
    output logic [15:0] edge_count,
    output logic        count_valid,
    output logic        clk32_rise
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_BOOST  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_RUN    = 3'd3,
        ST_FAIL   = 3'd4
    } state_t;

    localparam logic [23:0] WIN_LAST   = 24'(WIN_CYCLES - 1);
    localparam logic [23:0] BOOST_LAST = 24'(BOOST_CYCLES - 1);
    localparam logic [15:0] MIN_CNT    = 16'(MIN_EDGES);
    localparam logic [15:0] MAX_CNT    = 16'(MAX_EDGES);
    localparam logic [3:0]  GOOD_REQ   = 4'(STABLE_WINDOWS);
    localparam logic [7:0]  NWIN_MAX   = 8'(TIMEOUT_WINDOWS);

    state_t      state_r, state_s;
    logic        s1_r, s2_r, s3_r;
    logic        rise_s;
    logic [23:0] win_r, win_s;
    logic [23:0] bcnt_r, bcnt_s;
    logic [15:0] ecnt_r, ecnt_s, total_s;
    logic [3:0]  good_r, good_s, good_inc_s;
    logic [7:0]  nwin_r, nwin_s, nwin_inc_s;
    logic        in_range_s, win_end_s;
    logic [15:0] edge_count_r, edge_count_s;
    logic        count_valid_r, count_valid_s;
    logic        clk32_rise_r;
    logic        osc_ena_r, osc_boost_r, ready_r, fail_r;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic inc);
        if (inc && (v != 16'hFFFF)) begin
            return v + 16'd1;
        end else begin
            return v;
        end
    endfunction

    // Next-state, window bookkeeping and edge-count capture.
    always_comb begin
        state_s       = state_r;
        win_s         = win_r;
        bcnt_s        = bcnt_r;
        ecnt_s        = ecnt_r;
        good_s        = good_r;
        nwin_s        = nwin_r;
        edge_count_s  = edge_count_r;
        count_valid_s = 1'b0;
        rise_s        = s2_r & ~s3_r;
        total_s       = sat_inc16(ecnt_r, rise_s);
        win_end_s     = (win_r == WIN_LAST);
        in_range_s    = (total_s >= MIN_CNT) && (total_s <= MAX_CNT);
        good_inc_s    = in_range_s ? (good_r + 4'd1) : 4'd0;
        nwin_inc_s    = nwin_r + 8'd1;

        if (!en) begin
            // Dropping the request aborts everything, even a window end in this cycle.
            state_s = ST_IDLE;
            win_s   = 24'd0;
            bcnt_s  = 24'd0;
            ecnt_s  = 16'd0;
            good_s  = 4'd0;
            nwin_s  = 8'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    win_s   = 24'd0;
                    bcnt_s  = 24'd0;
                    ecnt_s  = 16'd0;
                    good_s  = 4'd0;
                    nwin_s  = 8'd0;
                    state_s = ST_BOOST;
                end
                ST_BOOST: begin
                    if (bcnt_r == BOOST_LAST) begin
                        state_s = ST_SETTLE;
                        bcnt_s  = 24'd0;
                        win_s   = 24'd0;
                        ecnt_s  = 16'd0;
                    end else begin
                        bcnt_s  = bcnt_r + 24'd1;
                    end
                end
                ST_SETTLE, ST_RUN: begin
                    if (win_end_s) begin
                        win_s         = 24'd0;
                        ecnt_s        = 16'd0;
                        edge_count_s  = total_s;
                        count_valid_s = 1'b1;
                        if (state_r == ST_SETTLE) begin
                            good_s = good_inc_s;
                            nwin_s = nwin_inc_s;
                            // Reaching stability wins over a simultaneous timeout.
                            if (good_inc_s == GOOD_REQ) begin
                                state_s = ST_RUN;
                            end else if (nwin_inc_s == NWIN_MAX) begin
                                state_s = ST_FAIL;
                            end else begin
                                state_s = ST_SETTLE;
                            end
                        end else if (!in_range_s) begin
                            state_s = ST_FAIL;
                        end else begin
                            state_s = ST_RUN;
                        end
                    end else begin
                        win_s  = win_r + 24'd1;
                        ecnt_s = total_s;
                    end
                end
                ST_FAIL: begin
                    state_s = ST_FAIL;
                end
                default: begin
                    state_s = ST_IDLE;
                    win_s   = 24'd0;
                    bcnt_s  = 24'd0;
                    ecnt_s  = 16'd0;
                    good_s  = 4'd0;
                    nwin_s  = 8'd0;
                end
            endcase
        end
    end

    // Synchronizer, state, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_r          <= 1'b0;
            s2_r          <= 1'b0;
            s3_r          <= 1'b0;
            clk32_rise_r  <= 1'b0;
            state_r       <= ST_IDLE;
            win_r         <= 24'd0;
            bcnt_r        <= 24'd0;
            ecnt_r        <= 16'd0;
            good_r        <= 4'd0;
            nwin_r        <= 8'd0;
            edge_count_r  <= 16'd0;
            count_valid_r <= 1'b0;
            osc_ena_r     <= 1'b0;
            osc_boost_r   <= 1'b0;
            ready_r       <= 1'b0;
            fail_r        <= 1'b0;
        end else begin
            s1_r          <= dout;
            s2_r          <= s1_r;
            s3_r          <= s2_r;
            clk32_rise_r  <= rise_s;
            state_r       <= state_s;
            win_r         <= win_s;
            bcnt_r        <= bcnt_s;
            ecnt_r        <= ecnt_s;
            good_r        <= good_s;
            nwin_r        <= nwin_s;
            edge_count_r  <= edge_count_s;
            count_valid_r <= count_valid_s;
            // Outputs decode the next state so they change on the same edge as the state.
            osc_ena_r     <= (state_s == ST_BOOST) || (state_s == ST_SETTLE) || (state_s == ST_RUN);
            osc_boost_r   <= (state_s == ST_BOOST);
            ready_r       <= (state_s == ST_RUN);
            fail_r        <= (state_s == ST_FAIL);
        end
    end

    assign osc_ena     = osc_ena_r;
    assign osc_boost   = osc_boost_r;
    assign ready       = ready_r;
    assign fail        = fail_r;
    assign edge_count  = edge_count_r;
    assign count_valid = count_valid_r;
    assign clk32_rise  = clk32_rise_r;

endmodule

// File: tb/tb_xtal_osc_32k_ctrl.sv
// Randomized bench for xtal_osc_32k_ctrl: a window-level reference model feeds a scoreboard
// that a separate monitor drains on every count_valid, plus per-cycle level checks.
module tb_xtal_osc_32k_ctrl;

    localparam int WIN    = 1000;
    localparam int MINE   = 28;
    localparam int MAXE   = 38;
    localparam int BOOST  = 200;
    localparam int STABLE = 3;
    localparam int TMO    = 8;

    logic        clk = 1'b0;
    logic        rst_n, en, dout;
    logic        osc_ena, osc_boost, ready, fail, count_valid, clk32_rise;
    logic [15:0] edge_count;

    xtal_osc_32k_ctrl #(
        .WIN_CYCLES(WIN), .MIN_EDGES(MINE), .MAX_EDGES(MAXE),
        .BOOST_CYCLES(BOOST), .STABLE_WINDOWS(STABLE), .TIMEOUT_WINDOWS(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .dout(dout),
        .osc_ena(osc_ena), .osc_boost(osc_boost), .ready(ready), .fail(fail),
        .edge_count(edge_count), .count_valid(count_valid), .clk32_rise(clk32_rise)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int cnt;
        bit rdy;
        bit fl;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   cv_seen = 0;
    int   last_rst = 0;
    int   period = 0;
    int   gen_hi, gen_lo;
    bit   hist [0:99999];

    // Reference model: mode 0 idle, 1 starting (boost then settle), 2 run, 3 fail
    int   m_mode = 0, m_s = 0, m_next = 0, m_good = 0, m_nwin = 0, m_ec = 0;
    bit   m_ena, m_boost, m_rdy, m_fail;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, expv);
        end
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // sel: 0 = ready high, 1 = fail high, 2 = osc_boost low
    task automatic wait_for(input int sel, input int bound, output int t);
        t = -1;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if ((sel == 0 && ready === 1'b1) || (sel == 1 && fail === 1'b1) ||
                (sel == 2 && osc_boost === 1'b0)) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_timeout sel=%0d: event not seen within %0d cycles", sel, bound);
        end
    endtask

    // Rising edges of the sampled dout that land in the window ending at edge hi.
    function automatic int count_rises(input int lo, input int hi);
        int c = 0;
        for (int p = lo - 1; p <= hi - 2; p++) begin
            if (hist[p] && !hist[p - 1]) c++;
        end
        return c;
    endfunction

    // dout generator with +-1 cycle jitter on the low phase.
    initial begin
        dout = 1'b0;
        forever begin
            if (period == 0) begin
                dout = 1'b0;
                @(negedge clk);
            end else begin
                gen_hi = period / 2;
                gen_lo = period - gen_hi + $urandom_range(0, 2) - 1;
                dout = 1'b1;
                repeat (gen_hi) @(negedge clk);
                dout = 1'b0;
                repeat (gen_lo) @(negedge clk);
            end
        end
    end

    // Reference model, evaluated at each active edge on the values the DUT samples.
    initial begin
        forever begin
            int   cnt;
            bit   inr;
            exp_t e;
            @(posedge clk);
            cyc++;
            if (cyc < 100000) hist[cyc] = dout;
            if (!rst_n) begin
                m_mode = 0;
                m_ec = 0;
                last_rst = cyc;
            end else if (!en) begin
                m_mode = 0;
            end else if (m_mode == 0) begin
                m_mode = 1;
                m_s = cyc + BOOST;
                m_next = m_s + WIN;
                m_good = 0;
                m_nwin = 0;
            end else if ((m_mode == 1 || m_mode == 2) && cyc == m_next) begin
                cnt = count_rises(m_next - WIN, m_next);
                inr = (cnt >= MINE) && (cnt <= MAXE);
                m_ec = cnt;
                m_next = m_next + WIN;
                if (m_mode == 1) begin
                    m_good = inr ? m_good + 1 : 0;
                    m_nwin++;
                    if (m_good == STABLE) m_mode = 2;
                    else if (m_nwin == TMO) m_mode = 3;
                end else if (!inr) begin
                    m_mode = 3;
                end
                e.cyc = cyc;
                e.cnt = cnt;
                e.rdy = (m_mode == 2);
                e.fl  = (m_mode == 3);
                exp_q.push_back(e);
            end
            m_ena   = (m_mode == 1) || (m_mode == 2);
            m_boost = (m_mode == 1) && (cyc < m_s);
            m_rdy   = (m_mode == 2);
            m_fail  = (m_mode == 3);
        end
    end

    // Monitor: level checks every cycle, scoreboard pop on every count_valid.
    initial begin
        forever begin
            exp_t e;
            @(posedge clk);
            #1;
            chk("osc_ena", 32'(osc_ena), 32'(m_ena));
            chk("osc_boost", 32'(osc_boost), 32'(m_boost));
            chk("ready", 32'(ready), 32'(m_rdy));
            chk("fail", 32'(fail), 32'(m_fail));
            chk("edge_count", 32'(edge_count), 32'(m_ec));
            if (cyc >= last_rst + 4) begin
                chk("clk32_rise", 32'(clk32_rise), 32'(hist[cyc - 2] & ~hist[cyc - 3]));
            end
            if (count_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("cv_unexpected", 32'(count_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    cv_seen++;
                    chk("sb_cycle", 32'(cyc), 32'(e.cyc));
                    chk("sb_edge_count", 32'(edge_count), 32'(e.cnt));
                    chk("sb_ready", 32'(ready), 32'(e.rdy));
                    chk("sb_fail", 32'(fail), 32'(e.fl));
                end
            end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                chk("sb_missing_cv", 32'(count_valid), 32'd1);
            end
        end
    end

    // Directed scenarios with randomized gaps, phases and dout jitter.
    initial begin
        int e0, s0, t, r, nend, base, ec_hold, rst_edge;
        rst_n = 1'b0;
        en = 1'b0;
        period = 0;
        repeat (4) @(negedge clk);
        chk("reset_outputs", 32'({osc_ena, osc_boost, ready, fail, count_valid, clk32_rise, edge_count}), 32'd0);
        rst_n = 1'b1;
        repeat ($urandom_range(5, 20)) @(negedge clk);

        // Nominal start, then clock loss in RUN
        period = 30;
        repeat ($urandom_range(40, 80)) @(negedge clk);
        base = cv_seen;
        en = 1'b1;
        e0 = cyc + 1;
        s0 = e0 + BOOST;
        @(negedge clk);
        chk("boost_rise", 32'({osc_ena, osc_boost}), 32'd3);
        wait_for(2, 2 * BOOST, t);
        chk("boost_length", 32'(t - e0), 32'(BOOST));
        wait_for(0, BOOST + (STABLE + 1) * WIN, t);
        chk("ready_time", 32'(t - e0), 32'(BOOST + STABLE * WIN));
        chk("nominal_windows", 32'(cv_seen - base), 32'(STABLE));
        repeat ($urandom_range(100, 1500)) @(negedge clk);
        r = $urandom_range(1, 100);
        for (int i = 0; i < WIN && ((cyc - s0) % WIN) != r; i++) @(negedge clk);
        period = 0;
        nend = cyc - ((cyc - s0) % WIN) + WIN;
        wait_for(1, 2 * WIN, t);
        chk("loss_fail_time", 32'(t), 32'(nend));
        chk("loss_ready_drop", 32'({ready, osc_ena}), 32'd0);
        chk("loss_count_low", 32'(edge_count < 16'd28), 32'd1);
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        chk("fail_cleared", 32'({fail, ready, osc_ena, osc_boost}), 32'd0);

        // No oscillation: timeout after all settle windows
        repeat ($urandom_range(5, 30)) @(negedge clk);
        base = cv_seen;
        en = 1'b1;
        e0 = cyc + 1;
        wait_for(1, BOOST + TMO * WIN + 100, t);
        chk("noosc_fail_time", 32'(t - e0), 32'(BOOST + TMO * WIN));
        chk("noosc_state", 32'({osc_ena, ready, edge_count}), 32'd0);
        chk("noosc_windows", 32'(cv_seen - base), 32'(TMO));
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        chk("noosc_idle", 32'({fail, osc_ena}), 32'd0);

        // Two fast windows, then nominal: good restarts, ready after three more
        period = 20;
        repeat ($urandom_range(5, 30)) @(negedge clk);
        en = 1'b1;
        e0 = cyc + 1;
        s0 = e0 + BOOST;
        wait_until(s0 + 2 * WIN - 10);
        period = 30;
        wait_for(0, 4 * WIN, t);
        chk("oor_ready_time", 32'(t - e0), 32'(BOOST + 5 * WIN));
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);

        // Abort one cycle into BOOST
        repeat ($urandom_range(5, 30)) @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        chk("abort_boost_entered", 32'(osc_boost), 32'd1);
        en = 1'b0;
        @(negedge clk);
        chk("abort_boost_idle", 32'({osc_ena, osc_boost, count_valid}), 32'd0);

        // Abort exactly on a window-end cycle
        repeat ($urandom_range(5, 30)) @(negedge clk);
        en = 1'b1;
        e0 = cyc + 1;
        s0 = e0 + BOOST;
        wait_until(s0 + 2 * WIN - 1);
        ec_hold = m_ec;
        en = 1'b0;
        @(negedge clk);
        chk("abort_we_cv", 32'({count_valid, osc_ena}), 32'd0);
        chk("abort_we_edge_count", 32'(edge_count), 32'(ec_hold));

        // Synchronous reset while in RUN with en held high
        repeat ($urandom_range(5, 30)) @(negedge clk);
        en = 1'b1;
        e0 = cyc + 1;
        wait_for(0, BOOST + (STABLE + 1) * WIN, t);
        chk("run_again_ready", 32'(t - e0), 32'(BOOST + STABLE * WIN));
        repeat ($urandom_range(10, 900)) @(negedge clk);
        rst_n = 1'b0;
        rst_edge = cyc + 1;
        @(negedge clk);
        rst_n = 1'b1;
        chk("srst_outputs", 32'({osc_ena, osc_boost, ready, fail, count_valid, clk32_rise, edge_count}), 32'd0);
        @(negedge clk);
        chk("srst_reboost", 32'({osc_ena, osc_boost}), 32'd3);
        wait_for(0, BOOST + (STABLE + 1) * WIN, t);
        chk("srst_ready_time", 32'(t - rst_edge), 32'(1 + BOOST + STABLE * WIN));
        @(negedge clk);
        en = 1'b0;
        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/xtal_osc_32k_ctrl.md
# xtal_osc_32k_ctrl

Digital start-up controller and clock monitor for the 32.768 kHz crystal oscillator. It drives the oscillator's `ena` and `boost` inputs, samples the oscillator's `dout` in the system clock domain, measures its edge rate over fixed windows, and reports when the 32k clock is stable (`ready`) or missing or out of range (`fail`). It sits in the always-on digital domain between the power/clock manager and the oscillator macro.

## Interface
- `WIN_CYCLES`, 100000: system clock cycles per measurement window (24-bit counter, ≥ 2).
- `MIN_EDGES`, 300: minimum acceptable rising edges per window.
- `MAX_EDGES`, 356: maximum acceptable rising edges per window. `MIN_EDGES` > `MAX_EDGES` is illegal.
- `BOOST_CYCLES`, 50000: cycles spent in BOOST (24-bit, ≥ 1).
- `STABLE_WINDOWS`, 4: consecutive in-range windows required for `ready` (1–15).
- `TIMEOUT_WINDOWS`, 64: total SETTLE windows allowed before `fail` (1–255).

Ports (name, direction, width, meaning):
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset. **Synchronous, active-low, on the single clock `clk`.**
- `en`  in  1  level request to run the oscillator.
- `dout`  in  1  oscillator digital output; asynchronous to `clk`.
- `osc_ena`  out  1  drives oscillator `ena`.
- `osc_boost`  out  1  drives oscillator `boost`.
- `ready`  out  1  32k clock verified stable.
- `fail`  out  1  start-up timeout or clock lost; sticky until `en` falls.
- `edge_count`  out  16  rising-edge count of the last completed window.
- `count_valid`  out  1  one-cycle pulse when `edge_count` updates.
- `clk32_rise`  out  1  one-cycle pulse per synchronized `dout` rising edge.

## Operation
- Synchronizer: two flops (s1, s2), then a history flop s3. The rise condition is s2 & ~s3, registered into `clk32_rise`.
- The FSM has five states: IDLE, BOOST, SETTLE, RUN and FAIL. All outputs are registered.
- IDLE:
  - `osc_ena`=0, `osc_boost`=0, `ready`=0, `fail`=0.
  - `en`=1 → BOOST.
- BOOST:
  - `osc_ena`=1, `osc_boost`=1.
  - After `BOOST_CYCLES` cycles → SETTLE.
  - Edges are ignored and no windows run.
- SETTLE:
  - `osc_ena`=1, `osc_boost`=0.
  - The window counter and edge counter restart on entry.
  - At each window end the window is in range if `MIN_EDGES` ≤ count ≤ `MAX_EDGES`.
  - An in-range window increments `good`. An out-of-range window clears `good`.
  - Every window increments `nwin`.
  - `good` reaches `STABLE_WINDOWS` → RUN. This takes priority if `nwin` reaches `TIMEOUT_WINDOWS` at the same window end.
  - Otherwise `nwin` = `TIMEOUT_WINDOWS` → FAIL.
- RUN:
  - `osc_ena`=1, `ready`=1.
  - Windows continue back-to-back.
  - Any out-of-range window → FAIL (`ready` drops in the same cycle `fail` rises).
- FAIL:
  - `osc_ena`=0, `fail`=1, `ready`=0.
  - Stays until `en`=0.
- `en`=0 in any state → IDLE on the next edge.
  - This clears `good`, `nwin`, the counters, `ready` and `fail`.
  - `edge_count` holds its last value.
- Edge counter:
  - 16-bit, saturates at 0xFFFF.
  - A rise in the final cycle of a window counts toward that window.
  - The counter restarts from 0 (or 1 if a rise occurs on the first cycle) for the next window.

## Timing
- Reset values: state IDLE, s1/s2/s3=0, all outputs 0, `edge_count`=0.
- `dout` rise to `clk32_rise`: the pulse is high in the cycle after the 3rd `clk` edge that samples `dout` high.
- `en` rise: `osc_ena` and `osc_boost` go to 1 after 1 edge.
- BOOST exit: `osc_boost` goes to 0 exactly `BOOST_CYCLES` cycles after it rose.
- Window end: `edge_count` and `count_valid` update on the same edge as the resulting state change, so `ready`/`fail` change coincident with `count_valid`.
- If `en` falls on a window-end cycle, IDLE wins and `count_valid` stays 0.
- If `rst_n`=0 mid-operation, all state returns to reset values on the next edge regardless of `en`.

## Test plan
The bench uses `WIN_CYCLES`=1000, `MIN_EDGES`=28, `MAX_EDGES`=38, `BOOST_CYCLES`=200, `STABLE_WINDOWS`=3, `TIMEOUT_WINDOWS`=8, and `dout` period 30 clk cycles (33–34 edges per window).
- **Nominal start:** `en`=1 at t0.
  - `osc_boost` is high for 200 cycles.
  - `count_valid` pulses 3 times with `edge_count` 33 or 34.
  - `ready`=1 at t0+1+200+3000.
- **No oscillation:** `dout` stuck at 0.
  - 8 windows with `edge_count`=0.
  - `fail`=1 and `osc_ena`=0 at the 8th window end.
  - `en`=0 returns to IDLE with `fail`=0.
- **Clock loss:** in RUN, stop `dout`.
  - At the next window end `edge_count` is below 28.
  - `ready` falls and `fail` rises in the same cycle.
- **Out-of-range then recovery:** `dout` period 20 (50 edges) for 2 windows, then period 30.
  - `good` resets; `ready` is asserted after 3 further good windows, within the 8-window timeout.
- **Abort:** `en`=0 one cycle into BOOST, and separately exactly on a window-end cycle.
  - IDLE next edge, `count_valid` stays 0, `edge_count` is unchanged.
- **Synchronous reset:** `rst_n`=0 for 1 cycle while in RUN.
  - All outputs are 0 and the state is IDLE after that edge.
  - With `en` still 1, BOOST is re-entered on the following edge.
